machine_ctl: RTL and testbench

Parametrised instruction-sequencing controller for the accumulator CPU. It is the successor to the fixed 8-state controller. It supports a configurable number of instruction-fetch words, memory wait-state insertion, a sticky halt with resume, and an instruction-complete strobe. It sits between the instruction register and opcode decode on one side and the PC, accumulator, RAM/ROM and data-bus driver on the other.

---
 rtl/machine_pkg.sv | 48 ++++
 rtl/machine_word_cnt.sv | 26 ++
 rtl/machine_ctl.sv | 198 +++++++++++++++++++
 tb/tb_machine_ctl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_pkg.sv
// Shared types for the accumulator CPU sequencing controller:
// opcodes, state encodings, and the registered control bundle.
package machine_pkg;

    localparam int MAX_FETCH_WORDS = 4;

    localparam logic [2:0] OP_HLT  = 3'd0;
    localparam logic [2:0] OP_SKZ  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ANDD = 3'd3;
    localparam logic [2:0] OP_XORR = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STO  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    // The state register names the state whose outputs are registered
    // at the next falling edge. FETCH[0] has its own code; FETCH[k>0]
    // shares S_FETCH and is indexed by the word counter.
    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH  = 4'd1,
        S_IDLE   = 4'd2,
        S_DECODE = 4'd3,
        S_HALT   = 4'd4,
        S_OPER   = 4'd5,
        S_EXEC   = 4'd6,
        S_POST   = 4'd7,
        S_TAIL   = 4'd8
    } state_t;

    typedef struct packed {
        logic inc_pc;
        logic load_acc;
        logic load_pc;
        logic rd;
        logic wr;
        logic load_ir;
        logic datactl_ena;
        logic halt;
        logic instr_done;
    } ctl_t;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ANDD) ||
               (op == OP_XORR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/machine_word_cnt.sv
// 2-bit down-counter with load and hold, used for the fetch-word index
// and the tail length. Ports: clk1 (falling edge), ena (async low reset),
// hold (freeze), load/load_val, dec, cnt.
module machine_word_cnt (
    input  logic       clk1,
    input  logic       ena,
    input  logic       hold,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       dec,
    output logic [1:0] cnt
);

    always_ff @(negedge clk1 or negedge ena) begin
        if (!ena) begin
            cnt <= 2'd0;
        end else if (!hold) begin
            if (load) begin
                cnt <= load_val;
            end else if (dec) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/machine_ctl.sv
// Instruction-sequencing controller: fetch, decode, halt/resume, optional
// memory wait states (macro MACHINE_CTL_WAIT_EN), instruction-done strobe.
// Ports: clk1 (falling edge), ena (async low reset), opcode, zero,
// mem_ready, resume; registered strobes inc_pc, load_acc, load_pc, rd,
// wr, load_ir, datactl_ena, halt, instr_done.
module machine_ctl
    import machine_pkg::*;
#(
    parameter int FETCH_WORDS = 2
) (
    input  logic       clk1,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic       instr_done
);

    if (FETCH_WORDS < 1 || FETCH_WORDS > MAX_FETCH_WORDS) begin : g_bad_fw
        $error("machine_ctl: FETCH_WORDS must be 1..4");
    end

    // Both the extra fetch words and the tail run FETCH_WORDS-1 cycles
    // (tail at least one), so the counter preload is shared.
    localparam logic [1:0] CNT_INIT =
        (FETCH_WORDS > 1) ? 2'(FETCH_WORDS - 2) : 2'd0;
    localparam logic TAIL_INC = (FETCH_WORDS > 1);
    localparam logic ONE_WORD = (FETCH_WORDS == 1);

    state_t     state;
    state_t     state_nxt;
    ctl_t       ctl;
    ctl_t       ctl_nxt;
    logic       skip;
    logic       skip_nxt;
    logic       cnt_load;
    logic       cnt_dec;
    logic       stall;
    logic [1:0] cnt;

    logic op_hlt;
    logic op_skz;
    logic op_alu;
    logic op_sto;
    logic op_jmp;

    assign op_hlt = (opcode == OP_HLT);
    assign op_skz = (opcode == OP_SKZ);
    assign op_alu = is_alu(opcode);
    assign op_sto = (opcode == OP_STO);
    assign op_jmp = (opcode == OP_JMP);

`ifdef MACHINE_CTL_WAIT_EN
    // A memory phase stays put, outputs included, until memory is ready.
    assign stall = (ctl.rd | ctl.wr) & ~mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign stall = 1'b0;
`endif

    machine_word_cnt u_cnt (
        .clk1     (clk1),
        .ena      (ena),
        .hold     (stall),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .cnt      (cnt)
    );

    always_comb begin
        state_nxt = S_FETCH0;
        ctl_nxt   = '0;
        skip_nxt  = skip;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            S_FETCH0, S_HALT: begin
                // Resume re-enters the fetch directly.
                if (state == S_FETCH0 || resume) begin
                    ctl_nxt.rd      = 1'b1;
                    ctl_nxt.load_ir = 1'b1;
                    skip_nxt        = 1'b0;
                    cnt_load        = 1'b1;
                    state_nxt       = ONE_WORD ? S_IDLE : S_FETCH;
                end else begin
                    ctl_nxt.halt = 1'b1;
                    state_nxt    = S_HALT;
                end
            end
            S_FETCH: begin
                ctl_nxt.rd      = 1'b1;
                ctl_nxt.load_ir = 1'b1;
                ctl_nxt.inc_pc  = 1'b1;
                if (cnt == 2'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_dec   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_IDLE: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ctl_nxt.inc_pc = 1'b1;
                ctl_nxt.halt   = op_hlt;
                state_nxt      = op_hlt ? S_HALT : S_OPER;
            end
            S_OPER: begin
                unique case (1'b1)
                    op_jmp:  ctl_nxt.load_pc     = 1'b1;
                    op_alu:  ctl_nxt.rd          = 1'b1;
                    op_sto:  ctl_nxt.datactl_ena = 1'b1;
                    default: ;
                endcase
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_alu: begin
                        ctl_nxt.load_acc = 1'b1;
                        ctl_nxt.rd       = 1'b1;
                    end
                    op_jmp: begin
                        ctl_nxt.inc_pc  = 1'b1;
                        ctl_nxt.load_pc = 1'b1;
                    end
                    op_sto: begin
                        ctl_nxt.wr          = 1'b1;
                        ctl_nxt.datactl_ena = 1'b1;
                    end
                    op_skz: begin
                        skip_nxt       = zero;
                        ctl_nxt.inc_pc = zero;
                    end
                    default: ;
                endcase
                state_nxt = S_POST;
            end
            S_POST: begin
                ctl_nxt.datactl_ena = op_sto;
                ctl_nxt.rd          = op_alu;
                cnt_load            = 1'b1;
                state_nxt           = S_TAIL;
            end
            S_TAIL: begin
                // Remaining skip increments bring the PC past a whole
                // multi-word instruction.
                ctl_nxt.inc_pc = skip & TAIL_INC;
                if (cnt == 2'd0) begin
                    ctl_nxt.instr_done = 1'b1;
                    state_nxt          = S_FETCH0;
                end else begin
                    cnt_dec   = 1'b1;
                    state_nxt = S_TAIL;
                end
            end
            default: begin
                skip_nxt  = 1'b0;
                state_nxt = S_FETCH0;
            end
        endcase
    end

    always_ff @(negedge clk1 or negedge ena) begin
        if (!ena) begin
            state <= S_FETCH0;
            ctl   <= '0;
            skip  <= 1'b0;
        end else if (!stall) begin
            state <= state_nxt;
            ctl   <= ctl_nxt;
            skip  <= skip_nxt;
        end
    end

    assign inc_pc      = ctl.inc_pc;
    assign load_acc    = ctl.load_acc;
    assign load_pc     = ctl.load_pc;
    assign rd          = ctl.rd;
    assign wr          = ctl.wr;
    assign load_ir     = ctl.load_ir;
    assign datactl_ena = ctl.datactl_ena;
    assign halt        = ctl.halt;
    assign instr_done  = ctl.instr_done;

endmodule

// File: tb/tb_machine_ctl.sv
// Directed testbench for machine_ctl: vector table on FETCH_WORDS=2,
// plus sequences for waits, skip, halt/resume, reset and FETCH_WORDS 1/3.
module tb_machine_ctl;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3;
    localparam logic [2:0] XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic       clk1;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;

    // {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, done}
    logic [8:0] o1, o2, o3;

    machine_ctl #(.FETCH_WORDS(1)) u1 (
        .clk1(clk1), .ena(ena), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .inc_pc(o1[8]), .load_acc(o1[7]), .load_pc(o1[6]), .rd(o1[5]),
        .wr(o1[4]), .load_ir(o1[3]), .datactl_ena(o1[2]), .halt(o1[1]),
        .instr_done(o1[0])
    );

    machine_ctl #(.FETCH_WORDS(2)) u2 (
        .clk1(clk1), .ena(ena), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .inc_pc(o2[8]), .load_acc(o2[7]), .load_pc(o2[6]), .rd(o2[5]),
        .wr(o2[4]), .load_ir(o2[3]), .datactl_ena(o2[2]), .halt(o2[1]),
        .instr_done(o2[0])
    );

    machine_ctl #(.FETCH_WORDS(3)) u3 (
        .clk1(clk1), .ena(ena), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .inc_pc(o3[8]), .load_acc(o3[7]), .load_pc(o3[6]), .rd(o3[5]),
        .wr(o3[4]), .load_ir(o3[3]), .datactl_ena(o3[2]), .halt(o3[1]),
        .instr_done(o3[0])
    );

    initial clk1 = 1'b1;
    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle masks for one FETCH_WORDS=2 instruction; bit i is cycle i+1.
    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [7:0] rd, wr, inc, ir, acc, pc, dctl, done;
    } vec_t;

    vec_t vt[9];

    task automatic do_reset();
        @(posedge clk1);
        ena = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        ena = 1'b1;
    endtask

    // Runs one instruction on the chosen instance. mem_ready is low for
    // the edges following samples lo_start..lo_start+lo_n-1.
    task automatic measure(input int fw, input int lo_start, input int lo_n,
                           output int len, output int incs, output int wrs,
                           output int rds);
        logic [8:0] ob;
        len  = -1;
        incs = 0;
        wrs  = 0;
        rds  = 0;
        mem_ready = !(0 >= lo_start && 0 < lo_start + lo_n);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk1);
            ob = (fw == 1) ? o1 : (fw == 3) ? o3 : o2;
            incs += int'(ob[8]);
            wrs  += int'(ob[4]);
            rds  += int'(ob[5]);
            mem_ready = !(c >= lo_start && c < lo_start + lo_n);
            if (ob[0]) begin
                len = c;
                break;
            end
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] m_rd, m_wr, m_inc, m_ir, m_acc, m_pc, m_dc, m_dn, m_h;
        int len, incs, wrs, rds, hcnt, dcnt, ocnt;

        vt[0] = '{ADD,  1'b0, 8'h73, 8'h00, 8'h0A, 8'h03, 8'h20, 8'h00, 8'h00, 8'h80};
        vt[1] = '{ANDD, 1'b1, 8'h73, 8'h00, 8'h0A, 8'h03, 8'h20, 8'h00, 8'h00, 8'h80};
        vt[2] = '{XORR, 1'b0, 8'h73, 8'h00, 8'h0A, 8'h03, 8'h20, 8'h00, 8'h00, 8'h80};
        vt[3] = '{LDA,  1'b0, 8'h73, 8'h00, 8'h0A, 8'h03, 8'h20, 8'h00, 8'h00, 8'h80};
        vt[4] = '{STO,  1'b0, 8'h03, 8'h20, 8'h0A, 8'h03, 8'h00, 8'h00, 8'h70, 8'h80};
        vt[5] = '{JMP,  1'b1, 8'h03, 8'h00, 8'h2A, 8'h03, 8'h00, 8'h30, 8'h00, 8'h80};
        vt[6] = '{SKZ,  1'b1, 8'h03, 8'h00, 8'hAA, 8'h03, 8'h00, 8'h00, 8'h00, 8'h80};
        vt[7] = '{SKZ,  1'b0, 8'h03, 8'h00, 8'h0A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h80};
        vt[8] = '{LDA,  1'b1, 8'h73, 8'h00, 8'h0A, 8'h03, 8'h20, 8'h00, 8'h00, 8'h80};

        ena = 1'b1;
        opcode = LDA;
        zero = 1'b0;
        mem_ready = 1'b1;
        resume = 1'b0;
        #1 ena = 1'b0;
        #20;
        check("reset_fw1", 32'(o1), 32'h0);
        check("reset_fw2", 32'(o2), 32'h0);
        check("reset_fw3", 32'(o3), 32'h0);
        @(posedge clk1);
        ena = 1'b1;

        for (int v = 0; v < 9; v++) begin
            opcode = vt[v].op;
            zero   = vt[v].z;
            {m_rd, m_wr, m_inc, m_ir, m_acc, m_pc, m_dc, m_dn, m_h} = '0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk1);
                m_inc[c] = o2[8];
                m_acc[c] = o2[7];
                m_pc[c]  = o2[6];
                m_rd[c]  = o2[5];
                m_wr[c]  = o2[4];
                m_ir[c]  = o2[3];
                m_dc[c]  = o2[2];
                m_h[c]   = o2[1];
                m_dn[c]  = o2[0];
            end
            check($sformatf("v%0d_rd", v), 32'(m_rd), 32'(vt[v].rd));
            check($sformatf("v%0d_wr", v), 32'(m_wr), 32'(vt[v].wr));
            check($sformatf("v%0d_inc_pc", v), 32'(m_inc), 32'(vt[v].inc));
            check($sformatf("v%0d_load_ir", v), 32'(m_ir), 32'(vt[v].ir));
            check($sformatf("v%0d_load_acc", v), 32'(m_acc), 32'(vt[v].acc));
            check($sformatf("v%0d_load_pc", v), 32'(m_pc), 32'(vt[v].pc));
            check($sformatf("v%0d_datactl", v), 32'(m_dc), 32'(vt[v].dctl));
            check($sformatf("v%0d_done", v), 32'(m_dn), 32'(vt[v].done));
            check($sformatf("v%0d_halt", v), 32'(m_h), 32'h0);
        end

`ifdef MACHINE_CTL_WAIT_EN
        do_reset();
        opcode = STO;
        measure(2, 6, 3, len, incs, wrs, rds);
        check("sto_wait_len", 32'(len), 32'd11);
        check("sto_wait_wr", 32'(wrs), 32'd4);
        opcode = LDA;
        measure(2, 1, 2, len, incs, wrs, rds);
        check("lda_fetch_wait_len", 32'(len), 32'd10);
        check("lda_fetch_wait_rd", 32'(rds), 32'd7);
        measure(2, 3, 2, len, incs, wrs, rds);
        check("lda_idle_lowrdy_len", 32'(len), 32'd8);
`else
        do_reset();
        opcode = ADD;
        measure(2, 0, 50, len, incs, wrs, rds);
        check("add_nowait_len", 32'(len), 32'd8);
        opcode = STO;
        measure(2, 0, 50, len, incs, wrs, rds);
        check("sto_nowait_len", 32'(len), 32'd8);
        check("sto_nowait_wr", 32'(wrs), 32'd1);
`endif

        do_reset();
        opcode = SKZ;
        zero = 1'b1;
        measure(3, 0, 0, len, incs, wrs, rds);
        check("skz3_z1_len", 32'(len), 32'd10);
        check("skz3_z1_inc", 32'(incs), 32'd6);
        zero = 1'b0;
        measure(3, 0, 0, len, incs, wrs, rds);
        check("skz3_z0_len", 32'(len), 32'd10);
        check("skz3_z0_inc", 32'(incs), 32'd3);

        do_reset();
        opcode = LDA;
        measure(1, 0, 0, len, incs, wrs, rds);
        check("lda1_len", 32'(len), 32'd7);
        check("lda1_inc", 32'(incs), 32'd1);
        opcode = SKZ;
        zero = 1'b1;
        measure(1, 0, 0, len, incs, wrs, rds);
        check("skz1_z1_len", 32'(len), 32'd7);
        check("skz1_z1_inc", 32'(incs), 32'd2);
        zero = 1'b0;

        do_reset();
        opcode = HLT;
        resume = 1'b1;
        hcnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk1);
            if (c < 4) hcnt += int'(o2[1]);
        end
        check("hlt_early_halt", 32'(hcnt), 32'd0);
        check("hlt_decode_halt", 32'(o2[1]), 32'd1);
        check("hlt_decode_inc", 32'(o2[8]), 32'd1);
        resume = 1'b0;
        hcnt = 0;
        dcnt = 0;
        ocnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk1);
            hcnt += int'(o2[1]);
            dcnt += int'(o2[0]);
            ocnt += int'((o2 & 9'h1FD) != 9'h0);
        end
        check("hlt_hold_cycles", 32'(hcnt), 32'd20);
        check("hlt_no_done", 32'(dcnt), 32'd0);
        check("hlt_other_outs", 32'(ocnt), 32'd0);
        resume = 1'b1;
        @(posedge clk1);
        resume = 1'b0;
        check("resume_halt", 32'(o2[1]), 32'd0);
        check("resume_rd", 32'(o2[5]), 32'd1);
        check("resume_load_ir", 32'(o2[3]), 32'd1);

        do_reset();
        opcode = STO;
        for (int c = 1; c <= 6; c++) @(posedge clk1);
        check("sto_exec_wr", 32'(o2[4]), 32'd1);
        check("sto_exec_dctl", 32'(o2[2]), 32'd1);
        ena = 1'b0;
        #1;
        check("async_rst_wr", 32'(o2[4]), 32'd0);
        check("async_rst_dctl", 32'(o2[2]), 32'd0);
        check("async_rst_all", 32'(o2), 32'd0);
        @(posedge clk1);
        ena = 1'b1;
        @(posedge clk1);
        check("post_rst_rd", 32'(o2[5]), 32'd1);
        check("post_rst_load_ir", 32'(o2[3]), 32'd1);
        check("post_rst_inc", 32'(o2[8]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
